// File: rtl/cacheline_adapter.sv
// Cacheline adapter: one 256-bit line request from L1 is served as a 4-beat 64-bit pmem burst.
// Optional performance counters are enabled with `define CACHELINE_ADAPTER_PERF_EN.
module cacheline_adapter #(
    parameter int LINE_W = 256,
    parameter int BEAT_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       line_addr_i,
    input  logic              line_read_i,
    input  logic              line_write_i,
    input  logic [LINE_W-1:0] line_wdata_i,
    output logic [LINE_W-1:0] line_rdata_o,
    output logic              line_resp_o,
    output logic [31:0]       pmem_address_o,
    output logic              pmem_read_o,
    output logic              pmem_write_o,
    output logic [BEAT_W-1:0] pmem_wdata_o,
    input  logic [BEAT_W-1:0] pmem_rdata_i,
    input  logic              pmem_resp_i
`ifdef CACHELINE_ADAPTER_PERF_EN
    ,
    output logic [31:0]       rd_bursts_o,
    output logic [31:0]       wr_bursts_o,
    output logic [31:0]       stall_cycles_o
`endif
);

    localparam int NBEATS = LINE_W / BEAT_W;
    localparam int K_W    = $clog2(NBEATS);
    localparam int OFF_W  = $clog2(LINE_W / 8);
    localparam logic [K_W-1:0] LAST_BEAT = K_W'(NBEATS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [K_W-1:0]    k_q, k_d;
    logic [31:0]       addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic [LINE_W-1:0] rdata_q, rdata_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // A simultaneous read and write request is resolved in favour of the read.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (line_read_i) begin
                    addr_d  = {line_addr_i[31:OFF_W], OFF_W'(0)};
                    k_d     = '0;
                    state_d = READ;
                end else if (line_write_i) begin
                    addr_d  = {line_addr_i[31:OFF_W], OFF_W'(0)};
                    wdata_d = line_wdata_i;
                    k_d     = '0;
                    state_d = WRITE;
                end
            end
            READ: begin
                if (pmem_resp_i) begin
                    rdata_d[k_q*BEAT_W +: BEAT_W] = pmem_rdata_i;
                    k_d = k_q + K_W'(1);
                    if (k_q == LAST_BEAT) begin
                        state_d = RESP;
                    end
                end
            end
            WRITE: begin
                if (pmem_resp_i) begin
                    k_d = k_q + K_W'(1);
                    if (k_q == LAST_BEAT) begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign line_rdata_o   = rdata_q;
    assign line_resp_o    = (state_q == RESP);
    assign pmem_address_o = addr_q;
    assign pmem_read_o    = (state_q == READ);
    assign pmem_write_o   = (state_q == WRITE);
    assign pmem_wdata_o   = (state_q == WRITE) ? wdata_q[k_q*BEAT_W +: BEAT_W] : '0;

`ifdef CACHELINE_ADAPTER_PERF_EN
    logic [31:0] rd_bursts_q, rd_bursts_d;
    logic [31:0] wr_bursts_q, wr_bursts_d;
    logic [31:0] stall_cycles_q, stall_cycles_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_bursts_q    <= '0;
            wr_bursts_q    <= '0;
            stall_cycles_q <= '0;
        end else begin
            rd_bursts_q    <= rd_bursts_d;
            wr_bursts_q    <= wr_bursts_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    // Bursts are counted on the transition into RESP; stalls on unacknowledged busy cycles.
    always_comb begin
        rd_bursts_d    = rd_bursts_q;
        wr_bursts_d    = wr_bursts_q;
        stall_cycles_d = stall_cycles_q;
        if (state_d == RESP && state_q == READ) begin
            rd_bursts_d = rd_bursts_q + 32'd1;
        end
        if (state_d == RESP && state_q == WRITE) begin
            wr_bursts_d = wr_bursts_q + 32'd1;
        end
        if ((state_q == READ || state_q == WRITE) && !pmem_resp_i) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    assign rd_bursts_o    = rd_bursts_q;
    assign wr_bursts_o    = wr_bursts_q;
    assign stall_cycles_o = stall_cycles_q;
`endif

endmodule

// File: tb/tb_cacheline_adapter.sv
// Self-checking bench for cacheline_adapter: directed and randomized line operations
// against a behavioural memory/line model. Honours CACHELINE_ADAPTER_PERF_EN if defined.
module tb_cacheline_adapter;

    logic         clk;
    logic         rst;
    logic [31:0]  line_addr_i;
    logic         line_read_i;
    logic         line_write_i;
    logic [255:0] line_wdata_i;
    logic [255:0] line_rdata_o;
    logic         line_resp_o;
    logic [31:0]  pmem_address_o;
    logic         pmem_read_o;
    logic         pmem_write_o;
    logic [63:0]  pmem_wdata_o;
    logic [63:0]  pmem_rdata_i;
    logic         pmem_resp_i;
`ifdef CACHELINE_ADAPTER_PERF_EN
    logic [31:0]  rd_bursts_o;
    logic [31:0]  wr_bursts_o;
    logic [31:0]  stall_cycles_o;
`endif

    cacheline_adapter dut (
        .clk            (clk),
        .rst            (rst),
        .line_addr_i    (line_addr_i),
        .line_read_i    (line_read_i),
        .line_write_i   (line_write_i),
        .line_wdata_i   (line_wdata_i),
        .line_rdata_o   (line_rdata_o),
        .line_resp_o    (line_resp_o),
        .pmem_address_o (pmem_address_o),
        .pmem_read_o    (pmem_read_o),
        .pmem_write_o   (pmem_write_o),
        .pmem_wdata_o   (pmem_wdata_o),
        .pmem_rdata_i   (pmem_rdata_i),
        .pmem_resp_i    (pmem_resp_i)
`ifdef CACHELINE_ADAPTER_PERF_EN
        ,
        .rd_bursts_o    (rd_bursts_o),
        .wr_bursts_o    (wr_bursts_o),
        .stall_cycles_o (stall_cycles_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks_total  = 0;
    int checks_passed = 0;

    // Model state: last completed fill, and per-burst memory behaviour.
    logic [255:0] last_fill;
    int           wait_cfg [4];
    logic [63:0]  beat_cfg [4];
    int           model_rd_bursts = 0;
    int           model_wr_bursts = 0;
    int           model_stalls    = 0;

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [255:0] observed,
                               input logic [255:0] expected);
        checks_total++;
        assert (observed === expected) checks_passed++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    function automatic logic [255:0] randLine();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic randomBurst(input int max_wait);
        for (int i = 0; i < 4; i++) begin
            wait_cfg[i] = $urandom_range(0, max_wait);
            beat_cfg[i] = {$urandom, $urandom};
        end
    endtask

    // Runs one line operation from its IDLE request cycle through to the IDLE cycle after RESP.
    task automatic applyStimulus(input bit is_rd, input bit is_wr, input logic [31:0] addr,
                                 input logic [255:0] wdata, input bit keep_write);
        logic [255:0] exp_line;
        logic [31:0]  exp_addr;
        bit           do_read;
        bit           ack;
        int           wait_sum;
        do_read  = is_rd;
        exp_addr = {addr[31:5], 5'b0};
        exp_line = last_fill;
        wait_sum = 0;
        line_addr_i  = addr;
        line_wdata_i = wdata;
        line_read_i  = is_rd;
        line_write_i = is_wr;
        pmem_resp_i  = 1'b0;
        nextCycle();
        line_addr_i  = $urandom;
        line_wdata_i = randLine();
        for (int b = 0; b < 4; b++) begin
            for (int w = 0; w <= wait_cfg[b]; w++) begin
                ack          = (w == wait_cfg[b]);
                pmem_resp_i  = ack;
                pmem_rdata_i = ack ? beat_cfg[b] : {$urandom, $urandom};
                checkOutput("pmem_read_busy",  256'(pmem_read_o),  256'(do_read));
                checkOutput("pmem_write_busy", 256'(pmem_write_o), 256'(!do_read));
                checkOutput("pmem_address",    256'(pmem_address_o), 256'(exp_addr));
                checkOutput("line_resp_busy",  256'(line_resp_o),  256'(0));
                checkOutput("line_rdata_busy", line_rdata_o, exp_line);
                if (!do_read) checkOutput("pmem_wdata", 256'(pmem_wdata_o), 256'(wdata[64*b +: 64]));
                if (do_read && ack) exp_line[64*b +: 64] = beat_cfg[b];
                nextCycle();
            end
            wait_sum += wait_cfg[b];
        end
        pmem_resp_i = 1'b1;
        checkOutput("line_resp_pulse", 256'(line_resp_o),  256'(1));
        checkOutput("pmem_read_resp",  256'(pmem_read_o),  256'(0));
        checkOutput("pmem_write_resp", 256'(pmem_write_o), 256'(0));
        checkOutput("line_rdata_resp", line_rdata_o, exp_line);
        if (do_read) begin
            last_fill = exp_line;
            model_rd_bursts++;
        end else begin
            model_wr_bursts++;
        end
        model_stalls += wait_sum;
        line_read_i  = 1'b0;
        line_write_i = keep_write;
        nextCycle();
        checkOutput("line_resp_idle",  256'(line_resp_o),  256'(0));
        checkOutput("pmem_read_idle",  256'(pmem_read_o),  256'(0));
        checkOutput("pmem_write_idle", 256'(pmem_write_o), 256'(0));
        checkOutput("line_rdata_idle", line_rdata_o, last_fill);
        pmem_resp_i = 1'b0;
    endtask

    initial begin
        logic [255:0] line_d;
        rst          = 1'b1;
        line_addr_i  = '0;
        line_read_i  = 1'b0;
        line_write_i = 1'b0;
        line_wdata_i = '0;
        pmem_rdata_i = '0;
        pmem_resp_i  = 1'b0;
        last_fill    = '0;
        #2 rst = 1'b0;
        #2;
        checkOutput("reset_resp",   256'(line_resp_o),    256'(0));
        checkOutput("reset_read",   256'(pmem_read_o),    256'(0));
        checkOutput("reset_write",  256'(pmem_write_o),   256'(0));
        checkOutput("reset_wdata",  256'(pmem_wdata_o),   256'(0));
        checkOutput("reset_addr",   256'(pmem_address_o), 256'(0));
        checkOutput("reset_rdata",  line_rdata_o, 256'(0));
        @(posedge clk);
        #1 rst = 1'b1;
        $display("[TB] zero-wait read of 0x00001234");
        for (int i = 0; i < 4; i++) begin
            wait_cfg[i] = 0;
            beat_cfg[i] = {16{4'(i + 1)}};
        end
        applyStimulus(1'b1, 1'b0, 32'h0000_1234, randLine(), 1'b0);
        checkOutput("fill_pattern", last_fill,
                    {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}});

        $display("[TB] write with two wait cycles before each beat");
        for (int i = 0; i < 4; i++) wait_cfg[i] = 2;
        applyStimulus(1'b0, 1'b1, 32'hABCD_0040, randLine(), 1'b0);

        $display("[TB] simultaneous read and write request");
        randomBurst(2);
        line_d = randLine();
        applyStimulus(1'b1, 1'b1, 32'h0000_2000, line_d, 1'b1);
        randomBurst(2);
        applyStimulus(1'b0, 1'b1, 32'h0000_2000, line_d, 1'b0);

        $display("[TB] reset after two beats of a read");
        line_addr_i  = 32'h0000_3300;
        line_read_i  = 1'b1;
        nextCycle();
        pmem_resp_i  = 1'b1;
        pmem_rdata_i = {$urandom, $urandom};
        nextCycle();
        nextCycle();
        #1 rst = 1'b0;
        #1;
        checkOutput("abort_read",  256'(pmem_read_o),    256'(0));
        checkOutput("abort_resp",  256'(line_resp_o),    256'(0));
        checkOutput("abort_addr",  256'(pmem_address_o), 256'(0));
        checkOutput("abort_rdata", line_rdata_o, 256'(0));
        line_read_i = 1'b0;
        pmem_resp_i = 1'b0;
        last_fill   = '0;
        @(posedge clk);
        #1 rst = 1'b1;
`ifdef CACHELINE_ADAPTER_PERF_EN
        model_rd_bursts = 0;
        model_wr_bursts = 0;
        model_stalls    = 0;
`endif
        checkOutput("post_reset_resp", 256'(line_resp_o), 256'(0));
        randomBurst(1);
        applyStimulus(1'b1, 1'b0, 32'h0000_4460, randLine(), 1'b0);

        $display("[TB] back-to-back reads");
        randomBurst(0);
        applyStimulus(1'b1, 1'b0, 32'h1000_0000, randLine(), 1'b0);
        randomBurst(3);
        applyStimulus(1'b1, 1'b0, 32'h2000_0020, randLine(), 1'b0);

        $display("[TB] randomized operations");
        for (int n = 0; n < 8; n++) begin
            bit rd;
            rd = 1'($urandom_range(0, 1));
            randomBurst(3);
            applyStimulus(rd, !rd, $urandom, randLine(), 1'b0);
        end

`ifdef CACHELINE_ADAPTER_PERF_EN
        checkOutput("perf_rd_bursts", 256'(rd_bursts_o),    256'(32'(model_rd_bursts)));
        checkOutput("perf_wr_bursts", 256'(wr_bursts_o),    256'(32'(model_wr_bursts)));
        checkOutput("perf_stalls",    256'(stall_cycles_o), 256'(32'(model_stalls)));
`endif
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
